// File: rtl/pick_fifo_rr_drain_if.sv
// Bundle between the pick FIFO bank and the drain scheduler, plus the
// downstream valid/ready channel carrying the selected word and its source.
interface pick_fifo_rr_drain_if #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 8
);
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]       fifo_empty;
  logic [N_SRC*WIDTH-1:0] fifo_data;
  logic [N_SRC-1:0]       fifo_read;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [SRC_W-1:0]       out_src;

  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_read, out_data, out_valid, out_src
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_read, out_data, out_valid, out_src
  );
endinterface

// File: rtl/pick_fifo_rr_drain.sv
// Round-robin drain scheduler: pops one eligible FIFO head per load cycle,
// staying on a source for up to BURST words, into a registered output stage.
module pick_fifo_rr_drain #(
  parameter int N_SRC = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                ck,
  input  logic                reset,
  input  logic                enable,
  input  logic [N_SRC-1:0]    src_mask,
  pick_fifo_rr_drain_if.master bus,
  output logic                busy
);
  localparam int SRC_W = $clog2(N_SRC);
  localparam int CNT_W = $clog2(BURST + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [SRC_W-1:0] SRC_LAST  = SRC_W'(N_SRC - 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST);

  // Explicit compare-and-wrap keeps the pointer correct for non-power-of-2 N_SRC.
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    return (idx == SRC_LAST) ? {SRC_W{1'b0}} : idx + SRC_W'(1);
  endfunction

  logic [0:0]       state_q,     state_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SRC_W-1:0] out_src_q,   out_src_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q,      busy_d;
  logic [SRC_W-1:0] ptr_q,       ptr_d;
  logic [CNT_W-1:0] burst_q,     burst_d;

  logic [N_SRC-1:0] elig_s;
  logic             win_found_s;
  logic [SRC_W-1:0] win_idx_s;
  logic [SRC_W-1:0] scan_s;
  logic             take_s;
  logic             load_s;
  logic [SRC_W-1:0] load_idx_s;
  logic [N_SRC-1:0] fifo_read_s;

  // Winner search: first eligible source starting at ptr, wrapping around.
  always_comb begin
    elig_s      = ~bus.fifo_empty & src_mask;
    win_found_s = 1'b0;
    win_idx_s   = ptr_q;
    scan_s      = ptr_q;
    take_s      = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      take_s      = ~win_found_s & elig_s[scan_s];
      win_idx_s   = take_s ? scan_s : win_idx_s;
      win_found_s = win_found_s | take_s;
      scan_s      = next_idx(scan_s);
    end
  end

  // Next-state: decide whether this cycle loads a word, and from which source.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    burst_d     = burst_q;
    load_s      = 1'b0;
    load_idx_s  = win_idx_s;

    case (state_q)
      ST_IDLE: begin
        if (enable && win_found_s) begin
          load_s      = 1'b1;
          burst_d     = CNT_W'(1);
          ptr_d       = next_idx(win_idx_s);
          state_d     = ST_SEND;
          out_valid_d = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (!bus.out_ready) begin
          state_d = ST_SEND;
        end else if (enable && (burst_q < BURST_MAX) && elig_s[out_src_q]) begin
          load_s     = 1'b1;
          load_idx_s = out_src_q;
          burst_d    = burst_q + CNT_W'(1);
        end else if (enable && win_found_s) begin
          // Burst exhausted or source dried up: re-arbitrate without a bubble.
          load_s  = 1'b1;
          burst_d = CNT_W'(1);
          ptr_d   = next_idx(win_idx_s);
        end else begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    if (load_s) begin
      out_data_d = bus.fifo_data[load_idx_s*WIDTH +: WIDTH];
      out_src_d  = load_idx_s;
    end else begin
      out_data_d = out_data_d;
    end

    busy_d = (state_d == ST_SEND);
  end

  // Read pulse is combinational and suppressed while reset is held low.
  always_comb begin
    fifo_read_s = {N_SRC{1'b0}};
    if (load_s && reset) begin
      fifo_read_s[load_idx_s] = 1'b1;
    end else begin
      fifo_read_s = {N_SRC{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      out_data_q  <= {WIDTH{1'b0}};
      out_src_q   <= {SRC_W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= {SRC_W{1'b0}};
      burst_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      burst_q     <= burst_d;
    end
  end

  assign bus.fifo_read = fifo_read_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_pick_fifo_rr_drain.sv
// Bench for pick_fifo_rr_drain: queue-backed FIFO models, a delivery scoreboard,
// a table of single-load arbitration vectors and hand-written multi-cycle sequences.
module tb_pick_fifo_rr_drain;
  localparam int N_SRC = 4;
  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic             ck = 1'b0;
  logic             reset;
  logic             enable;
  logic [N_SRC-1:0] src_mask;
  logic             busy;

  pick_fifo_rr_drain_if #(.N_SRC(N_SRC), .WIDTH(WIDTH)) bus ();

  pick_fifo_rr_drain #(.N_SRC(N_SRC), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .ck       (ck),
    .reset    (reset),
    .enable   (enable),
    .src_mask (src_mask),
    .bus      (bus),
    .busy     (busy)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] ne;
    logic       en;
    logic [3:0] exp_read;
    logic       exp_valid;
    logic [1:0] exp_src;
    logic [7:0] exp_data;
  } vec_t;

  exp_t       sb [$];
  logic [7:0] src_q [N_SRC][$];
  vec_t       tv [7];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] word(input int s, input int w);
    return 8'((s << 4) | w);
  endfunction

  task automatic refresh();
    for (int i = 0; i < N_SRC; i++) begin
      bus.fifo_empty[i] = (src_q[i].size() == 0);
      bus.fifo_data[i*WIDTH +: WIDTH] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  task automatic fill(input int s, input int n);
    for (int w = 0; w < n; w++) src_q[s].push_back(word(s, w));
    refresh();
  endtask

  task automatic expect_w(input int s, input int w);
    exp_t e;
    e.src  = 2'(s);
    e.data = word(s, w);
    sb.push_back(e);
  endtask

  task automatic clear_bank();
    for (int i = 0; i < N_SRC; i++) src_q[i].delete();
    sb.delete();
    refresh();
  endtask

  task automatic reset_dut();
    @(posedge ck); #2;
    reset = 1'b0;
    clear_bank();
    enable = 1'b1;
    src_mask = 4'hF;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge ck);
    #2 reset = 1'b1;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (n < max_cyc && (sb.size() != 0 || bus.out_valid)) begin
      @(negedge ck);
      n++;
    end
    check("drain", 32'(sb.size() == 0 && !bus.out_valid), 32'd1);
  endtask

  // FIFO model: a read pulse seen at the edge pops the head shortly after.
  always @(posedge ck) begin
    logic [N_SRC-1:0] rd;
    rd = bus.fifo_read;
    #1;
    for (int i = 0; i < N_SRC; i++) begin
      if (rd[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    end
    refresh();
  end

  // Delivery monitor and read-pulse legality.
  always @(negedge ck) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (bus.fifo_read != 4'b0000) begin
        check("read_onehot", 32'($onehot(bus.fifo_read)), 32'd1);
        check("read_legal", 32'(bus.fifo_read & ~(~bus.fifo_empty & src_mask)), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check("sb_src", 32'(bus.out_src), 32'(e.src));
          check("sb_data", 32'(bus.out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tv[0] = '{4'hF, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tv[1] = '{4'hF, 4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tv[2] = '{4'hE, 4'h3, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tv[3] = '{4'hF, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tv[4] = '{4'h0, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tv[5] = '{4'h8, 4'h9, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tv[6] = '{4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};

    // Reset with all FIFOs holding a word.
    reset = 1'b0; enable = 1'b1; src_mask = 4'hF; bus.out_ready = 1'b1;
    clear_bank();
    for (int s = 0; s < N_SRC; s++) begin
      fill(s, 1);
      expect_w(s, 0);
    end
    repeat (3) begin
      @(posedge ck); @(negedge ck);
      check("rst_read", 32'(bus.fifo_read), 32'd0);
      check("rst_valid", 32'(bus.out_valid), 32'd0);
      check("rst_data", 32'(bus.out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    @(posedge ck); #2 reset = 1'b1;
    @(negedge ck);
    check("rst_first_pop", 32'(bus.fifo_read), 32'h1);
    wait_drain(20);

    // Table: one load from IDLE with ptr at 0.
    for (int v = 0; v < 7; v++) begin
      reset_dut();
      bus.out_ready = 1'b0;
      src_mask = tv[v].mask;
      enable = tv[v].en;
      for (int i = 0; i < N_SRC; i++) begin
        if (tv[v].ne[i]) src_q[i].push_back(8'hA0 + 8'(i));
      end
      refresh();
      @(negedge ck);
      check("tv_read", 32'(bus.fifo_read), 32'(tv[v].exp_read));
      @(negedge ck);
      check("tv_valid", 32'(bus.out_valid), 32'(tv[v].exp_valid));
      check("tv_src", 32'(bus.out_src), 32'(tv[v].exp_src));
      check("tv_data", 32'(bus.out_data), 32'(tv[v].exp_data));
    end

    // Single source, three words back to back.
    reset_dut();
    src_q[1].push_back(8'h11); src_q[1].push_back(8'h22); src_q[1].push_back(8'h33);
    refresh();
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.src = 2'd1;
      e.data = (k == 0) ? 8'h11 : (k == 1) ? 8'h22 : 8'h33;
      sb.push_back(e);
    end
    @(posedge ck);
    repeat (3) begin
      @(negedge ck);
      check("single_valid", 32'(bus.out_valid), 32'd1);
      check("single_src", 32'(bus.out_src), 32'd1);
    end
    @(negedge ck);
    check("single_idle_valid", 32'(bus.out_valid), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);

    // Round robin, 4 x 6 words, bursts of 4 then 2.
    reset_dut();
    for (int s = 0; s < N_SRC; s++) fill(s, 6);
    for (int s = 0; s < N_SRC; s++) for (int w = 0; w < 4; w++) expect_w(s, w);
    for (int s = 0; s < N_SRC; s++) for (int w = 4; w < 6; w++) expect_w(s, w);
    @(posedge ck);
    cnt = 0;
    repeat (24) begin
      @(negedge ck);
      if (bus.out_valid) cnt++;
    end
    check("rr_no_gaps", 32'(cnt), 32'd24);
    @(negedge ck);
    check("rr_idle", 32'(bus.out_valid), 32'd0);
    check("rr_empty_sb", 32'(sb.size()), 32'd0);

    // Backpressure mid-burst.
    reset_dut();
    for (int s = 0; s < N_SRC; s++) fill(s, 6);
    for (int s = 0; s < N_SRC; s++) for (int w = 0; w < 4; w++) expect_w(s, w);
    for (int s = 0; s < N_SRC; s++) for (int w = 4; w < 6; w++) expect_w(s, w);
    @(posedge ck); @(posedge ck); #2 bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge ck);
      check("bp_data", 32'(bus.out_data), 32'(word(0, 1)));
      check("bp_src", 32'(bus.out_src), 32'd0);
      check("bp_read", 32'(bus.fifo_read), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
    end
    @(posedge ck); #2 bus.out_ready = 1'b1;
    wait_drain(60);

    // Masked source is never popped.
    reset_dut();
    src_mask = 4'b1101;
    for (int s = 0; s < N_SRC; s++) fill(s, 2);
    for (int s = 0; s < N_SRC; s++) if (s != 1) begin expect_w(s, 0); expect_w(s, 1); end
    wait_drain(40);
    check("mask_src1_kept", 32'(src_q[1].size()), 32'd2);

    // Enable dropped while a word is held.
    reset_dut();
    bus.out_ready = 1'b0;
    fill(0, 4);
    expect_w(0, 0);
    @(posedge ck); #2 enable = 1'b0; bus.out_ready = 1'b1;
    repeat (4) begin
      @(negedge ck);
      check("en_no_pop", 32'(bus.fifo_read), 32'd0);
    end
    check("en_idle", 32'(bus.out_valid), 32'd0);
    check("en_busy", 32'(busy), 32'd0);
    check("en_left", 32'(src_q[0].size()), 32'd3);
    check("en_sb", 32'(sb.size()), 32'd0);

    // Reset in the middle of a burst.
    reset_dut();
    fill(0, 4);
    expect_w(0, 0);
    @(posedge ck); @(posedge ck); #2 reset = 1'b0;
    clear_bank();
    @(negedge ck);
    check("mid_rst_read", 32'(bus.fifo_read), 32'd0);
    @(posedge ck); @(negedge ck);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    @(posedge ck); #2 reset = 1'b1;
    src_q[0].push_back(word(0, 10)); src_q[1].push_back(word(1, 10));
    refresh();
    expect_w(0, 10); expect_w(1, 10);
    @(negedge ck);
    check("mid_rst_ptr0", 32'(bus.fifo_read), 32'h1);
    wait_drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
